// File: rtl/axi_axi2bram.sv
// ============================================================================
// Module   : axi_axi2bram
// Purpose  : AXI4 read master that copies a contiguous block of external
//            memory into the local input BRAM. Requests are split into 4 KB-safe
//            bursts, several reads are kept in flight, and every returned beat
//            is written to the next sequential BRAM address.
//            Optional feature macro: AXI_A2B_RRESP_CHECK_EN, which adds the
//            m_axi_rresp input and a sticky o_a2b_err flag.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_axi2bram #(
  parameter int AXI_ADDR_WIDTH      = 64,
  parameter int AXI_DATA_WIDTH      = 512,
  parameter int AXI_XFER_SIZE_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH     = 11,
  parameter int MAX_BURST_LEN       = 64,
  parameter int MAX_OUTSTANDING     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_a2b_start,
  output logic                           o_a2b_done,
  input  logic [AXI_ADDR_WIDTH-1:0]      i_a2b_data_addr,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_a2b_data_size_bytes,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                     m_axi_arlen,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic                           m_axi_rlast,
  output logic                           o_a2b_wren,
  output logic [BRAM_ADDR_WIDTH-1:0]     o_a2b_wraddr,
  output logic [AXI_DATA_WIDTH-1:0]      o_a2b_wrdata
`ifdef AXI_A2B_RRESP_CHECK_EN
  ,
  input  logic [1:0]                     m_axi_rresp,
  output logic                           o_a2b_err
`endif
);

  localparam int BYTES     = AXI_DATA_WIDTH / 8;
  localparam int LOG_BYTES = $clog2(BYTES);
  localparam int XW        = AXI_XFER_SIZE_WIDTH;
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XW-1:0]             rem_q, rem_d;
  logic [XW-1:0]             total_q, total_d;
  logic [XW-1:0]             recv_q, recv_d;
  logic [OUT_W-1:0]          out_q, out_d;
  logic                      arvalid_q, arvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                arlen_q, arlen_d;
  logic                      wren_q, wren_d;
  logic [BRAM_ADDR_WIDTH-1:0] wraddr_q, wraddr_d;
  logic [AXI_DATA_WIDTH-1:0] wrdata_q, wrdata_d;

  logic          start_ok, ar_hs, r_hs, rlast_hs, xfer_end, can_issue;
  logic [12:0]   gap_4k;
  logic [XW-1:0] beats_4k, burst_len, size_beats;
  logic [OUT_W:0] inflight;

  assign start_ok = i_a2b_start && (state_q == ST_IDLE);
  assign ar_hs    = arvalid_q && m_axi_arready;
  assign r_hs     = m_axi_rvalid && (state_q == ST_XFER);
  assign rlast_hs = r_hs && m_axi_rlast;
  assign xfer_end = (recv_q == total_q) && (out_q == '0) && !arvalid_q;

  assign size_beats = (i_a2b_data_size_bytes >> LOG_BYTES)
                    + {{(XW-1){1'b0}}, |i_a2b_data_size_bytes[LOG_BYTES-1:0]};

  // Bursts never cross a 4 KB page; addr_q is always beat-aligned.
  assign gap_4k   = 13'h1000 - {1'b0, addr_q[11:0]};
  assign beats_4k = XW'(gap_4k >> LOG_BYTES);

  always_comb begin
    burst_len = rem_q;
    if (burst_len > XW'(MAX_BURST_LEN)) burst_len = XW'(MAX_BURST_LEN);
    if (burst_len > beats_4k)           burst_len = beats_4k;
  end

  // The AR currently held on the bus counts against the in-flight limit.
  assign inflight  = {1'b0, out_q} + {{OUT_W{1'b0}}, arvalid_q};
  assign can_issue = (state_q == ST_XFER) && (rem_q != '0)
                   && (!arvalid_q || m_axi_arready)
                   && (inflight < (OUT_W+1)'(MAX_OUTSTANDING));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_a2b_start) state_d = ST_XFER;
      ST_XFER: if (xfer_end)    state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_a2b_done   = (state_q == ST_IDLE);
    m_axi_rready = (state_q == ST_XFER);
  end

  always_comb begin
    addr_d    = addr_q;
    rem_d     = rem_q;
    total_d   = total_q;
    recv_d    = recv_q;
    out_d     = out_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    wren_d    = r_hs;
    wraddr_d  = wraddr_q;
    wrdata_d  = wrdata_q;
    if (start_ok) begin
      addr_d  = i_a2b_data_addr & ~AXI_ADDR_WIDTH'(BYTES - 1);
      rem_d   = size_beats;
      total_d = size_beats;
      recv_d  = '0;
      out_d   = '0;
    end else if (state_q == ST_XFER) begin
      if (ar_hs) arvalid_d = 1'b0;
      if (can_issue) begin
        arvalid_d = 1'b1;
        araddr_d  = addr_q;
        arlen_d   = 8'(burst_len - 1'b1);
        addr_d    = addr_q + (AXI_ADDR_WIDTH'(burst_len) << LOG_BYTES);
        rem_d     = rem_q - burst_len;
      end
      case ({ar_hs, rlast_hs})
        2'b10:   out_d = out_q + 1'b1;
        2'b01:   out_d = out_q - 1'b1;
        default: out_d = out_q;
      endcase
      recv_d = recv_q + {{(XW-1){1'b0}}, r_hs};
    end
    if (r_hs) begin
      wraddr_d = recv_q[BRAM_ADDR_WIDTH-1:0];
      wrdata_d = m_axi_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      rem_q     <= '0;
      total_q   <= '0;
      recv_q    <= '0;
      out_q     <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      wren_q    <= 1'b0;
      wraddr_q  <= '0;
      wrdata_q  <= '0;
    end else begin
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      total_q   <= total_d;
      recv_q    <= recv_d;
      out_q     <= out_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      wren_q    <= wren_d;
      wraddr_q  <= wraddr_d;
      wrdata_q  <= wrdata_d;
    end
  end

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign o_a2b_wren    = wren_q;
  assign o_a2b_wraddr  = wraddr_q;
  assign o_a2b_wrdata  = wrdata_q;

`ifdef AXI_A2B_RRESP_CHECK_EN
  logic err_q, err_d;
  logic rresp_unused;
  assign rresp_unused = m_axi_rresp[0];

  // Only SLVERR/DECERR (rresp[1]) flag an error; data is kept regardless.
  always_comb begin
    err_d = err_q;
    if (start_ok)                     err_d = 1'b0;
    else if (r_hs && m_axi_rresp[1])  err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign o_a2b_err = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_axi2bram.sv
// ============================================================================
// Module   : tb_axi_axi2bram
// Purpose  : Self-checking bench for axi_axi2bram: table of directed transfers
//            against an AXI read-slave model, plus outstanding-limit, reset and
//            (with AXI_A2B_RRESP_CHECK_EN) error-flag sequences.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_axi2bram;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int XW = 32;
  localparam int BW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, done;
  logic [AW-1:0] a_in;
  logic [XW-1:0] s_in;
  logic          arvalid, arready, rvalid, rready, rlast, wren;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [DW-1:0] rdata, wrdata;
  logic [BW-1:0] wraddr;
`ifdef AXI_A2B_RRESP_CHECK_EN
  logic [1:0]    rresp;
  logic          err;
  int            err_at = -1;
`endif

  axi_axi2bram #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_XFER_SIZE_WIDTH(XW),
    .BRAM_ADDR_WIDTH(BW), .MAX_BURST_LEN(64), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_a2b_start(start), .o_a2b_done(done),
    .i_a2b_data_addr(a_in), .i_a2b_data_size_bytes(s_in),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_rdata(rdata), .m_axi_rlast(rlast),
    .o_a2b_wren(wren), .o_a2b_wraddr(wraddr), .o_a2b_wrdata(wrdata)
`ifdef AXI_A2B_RRESP_CHECK_EN
    , .m_axi_rresp(rresp), .o_a2b_err(err)
`endif
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [AW-1:0] a; int len; longint t; } burst_t;
  typedef struct {
    logic [AW-1:0] a; logic [XW-1:0] size; int beats; int nar;
    logic [AW-1:0] ar0; int len0; logic [AW-1:0] ar1; int len1; bit bp;
  } vec_t;

  burst_t        rq[$];
  logic [AW-1:0] ar_addr_q[$];
  int            ar_len_q[$], ar_out_q[$], rl_ar_q[$];
  logic [BW-1:0] wra_q[$];
  logic [DW-1:0] wrd_q[$];
  longint        wrc_q[$];
  bit            bp_mode = 1'b0;
  int            r_delay = 0;
  int            flush_gen = 0;
  int            r_cnt = 0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{a ^ 64'hC0DE_0000_0000_0000}};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // AXI read slave and write monitor: handshakes observed at negedge,
  // new input values driven 1 ns after posedge.
  initial begin
    int rbeat, cur_out, my_gen;
    bit consumed;
    rbeat = 0; cur_out = 0; my_gen = 0; consumed = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
`ifdef AXI_A2B_RRESP_CHECK_EN
    rresp = 2'd0;
`endif
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (arvalid && arready) begin
          ar_addr_q.push_back(araddr);
          ar_len_q.push_back(int'(arlen));
          rq.push_back('{araddr, int'(arlen), cyc + r_delay});
          cur_out++;
          ar_out_q.push_back(cur_out);
        end
        if (rvalid && rready) begin
          consumed = 1'b1;
          r_cnt++;
          if (rlast) begin
            rl_ar_q.push_back(ar_addr_q.size());
            cur_out--;
            void'(rq.pop_front());
            rbeat = 0;
          end else begin
            rbeat++;
          end
        end
        if (wren) begin
          wra_q.push_back(wraddr);
          wrd_q.push_back(wrdata);
          wrc_q.push_back(cyc);
        end
      end
      @(posedge clk);
      #1;
      if (my_gen != flush_gen) begin
        my_gen = flush_gen; rq.delete(); rbeat = 0; cur_out = 0;
        consumed = 1'b0; rvalid = 1'b0;
      end
      arready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!rvalid || consumed) begin
        rvalid = 1'b0; rlast = 1'b0; consumed = 1'b0;
        if (rq.size() > 0 && cyc >= rq[0].t && (!bp_mode || $urandom_range(0, 2) != 0)) begin
          rvalid = 1'b1;
          rdata  = pat(rq[0].a + 64'(rbeat) * 64);
          rlast  = (rbeat == rq[0].len);
`ifdef AXI_A2B_RRESP_CHECK_EN
          rresp  = (r_cnt == err_at) ? 2'd2 : 2'd0;
`endif
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int rdelay, input bit glitch);
    int ab, wb, n, low, good, nw;
    longint done_cyc;
    bit seen;
    logic [AW-1:0] base;
    ab = ar_addr_q.size(); wb = wra_q.size();
    bp_mode = v.bp; r_delay = rdelay;
    @(posedge clk); #1;
    start = 1'b1; a_in = v.a; s_in = v.size;
    @(posedge clk); #1;
    start = 1'b0; a_in = 64'hDEAD_BEEF_0000_0040; s_in = 32'd64;
    seen = 1'b0; low = 0; n = 0; done_cyc = 0;
    while (!seen && n < 30000) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1; done_cyc = cyc;
      end else begin
        low++;
        if (glitch && low == 5) start = 1'b1;
        if (glitch && low == 6) start = 1'b0;
      end
      n++;
    end
    check("done_seen", seen, 1);
    check("ar_count", ar_addr_q.size() - ab, v.nar);
    if (v.nar > 0 && ar_addr_q.size() > ab) begin
      check("ar0_addr", ar_addr_q[ab], v.ar0);
      check("ar0_len", ar_len_q[ab], v.len0);
    end
    if (v.nar > 1 && ar_addr_q.size() > ab + 1) begin
      check("ar1_addr", ar_addr_q[ab+1], v.ar1);
      check("ar1_len", ar_len_q[ab+1], v.len1);
    end
    nw = wra_q.size() - wb;
    check("wr_count", nw, v.beats);
    base = v.a & ~64'h3F;
    good = 0;
    for (int i = 0; i < nw; i++)
      if (wra_q[wb+i] == BW'(i) && wrd_q[wb+i] == pat(base + 64'(i) * 64)) good++;
    check("wr_data", good, v.beats);
    if (v.beats > 0 && nw > 0) check("done_after_last_wr", done_cyc - wrc_q[wb+nw-1], 1);
    if (v.size == 0) check("done_low_cycles", low, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    vec_t v;
    int ab, rb, mx;

    vecs[0] = '{64'h1000,  32'd4096,   64,   1,  64'h1000,  63, 64'h0,     0,  1'b0};
    vecs[1] = '{64'h1F80,  32'd512,    8,    2,  64'h1F80,  1,  64'h2000,  5,  1'b0};
    vecs[2] = '{64'h3000,  32'd100,    2,    1,  64'h3000,  1,  64'h0,     0,  1'b0};
    vecs[3] = '{64'h3000,  32'd0,      0,    0,  64'h0,     0,  64'h0,     0,  1'b0};
    vecs[4] = '{64'h1234,  32'd64,     1,    1,  64'h1200,  0,  64'h0,     0,  1'b1};
    vecs[5] = '{64'h0FC0,  32'd128,    2,    2,  64'h0FC0,  0,  64'h1000,  0,  1'b1};
    vecs[6] = '{64'h0,     32'd4160,   65,   2,  64'h0,     63, 64'h1000,  0,  1'b1};
    vecs[7] = '{64'h40000, 32'd131136, 2049, 33, 64'h40000, 63, 64'h41000, 63, 1'b0};

    rst_n = 1'b0; start = 1'b0; a_in = '0; s_in = '0;
    #1;
    check("rst_done", done, 1);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_wren", wren, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle_done", done, 1);
    check("idle_araddr", araddr, 0);
    check("idle_arlen", arlen, 0);
    check("idle_wraddr", wraddr, 0);
    check("idle_wrdata", |wrdata, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 0, 1'b0);

    // Outstanding limit with slow read data; a stray start mid-transfer.
    v  = '{64'h10000, 32'd24576, 384, 6, 64'h10000, 63, 64'h11000, 63, 1'b0};
    ab = ar_addr_q.size(); rb = rl_ar_q.size();
    run_vec(v, 50, 1'b1);
    if (rl_ar_q.size() > rb) check("ar_before_first_rlast", rl_ar_q[rb] - ab, 4);
    else                     check("rlast_seen", 0, 1);
    mx = 0;
    for (int i = ab; i < ar_out_q.size(); i++) if (ar_out_q[i] > mx) mx = ar_out_q[i];
    check("max_outstanding", mx, 4);

    // Asynchronous reset in the middle of a backpressured transfer.
    bp_mode = 1'b1; r_delay = 0;
    @(posedge clk); #1;
    start = 1'b1; a_in = 64'h20000; s_in = 32'd24576;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_busy", done, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_done", done, 1);
    check("arst_arvalid", arvalid, 0);
    check("arst_rready", rready, 0);
    check("arst_wren", wren, 0);
    check("arst_wraddr", wraddr, 0);
    check("arst_wrdata", |wrdata, 0);
    check("arst_araddr", araddr, 0);
    check("arst_arlen", arlen, 0);
    flush_gen++;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    v = vecs[1]; v.bp = 1'b1;
    run_vec(v, 0, 1'b0);

`ifdef AXI_A2B_RRESP_CHECK_EN
    v = '{64'h5000, 32'd512, 8, 1, 64'h5000, 7, 64'h0, 0, 1'b0};
    err_at = r_cnt + 2;
    run_vec(v, 0, 1'b0);
    check("err_set", err, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", err, 1);
    err_at = -1;
    run_vec(vecs[2], 0, 1'b0);
    check("err_cleared", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
